// File: rtl/sr_cmd_seq.sv
// Turns a valid/ready set/clear command stream into mutually exclusive s/r pulses, checks q_fb, then holds off.
// Optional build macro SR_CMD_SKIP_REDUNDANT_EN: skip DRIVE when q_fb already matches the command.
module sr_cmd_seq #(
    parameter int PULSE_LEN = 2,
    parameter int GAP       = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd_valid,
    input  logic cmd_op,
    output logic cmd_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic done,
    output logic err,
    input  logic err_clr
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, HOLDOFF} state_t;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       exp_q, exp_nxt;
    logic       err_nxt;
    logic       s_nxt, r_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        exp_nxt   = exp_q;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    exp_nxt = cmd_op;
                    cnt_nxt = 8'd0;
`ifdef SR_CMD_SKIP_REDUNDANT_EN
                    state_nxt = (q_fb == cmd_op) ? CHECK : DRIVE;
`else
                    state_nxt = DRIVE;
`endif
                end
            end
            DRIVE: begin
                if (cnt == PULSE_LAST) begin
                    state_nxt = CHECK;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            CHECK: begin
                cnt_nxt   = 8'd0;
                state_nxt = (GAP > 0) ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A mismatch in the same cycle as err_clr keeps err set.
        if (state == CHECK && q_fb != exp_q)
            err_nxt = 1'b1;
        else if (err_clr)
            err_nxt = 1'b0;

        // s/r are registered from the next state so both can never be high together.
        s_nxt = (state_nxt == DRIVE) &&  exp_nxt;
        r_nxt = (state_nxt == DRIVE) && !exp_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            exp_q <= 1'b0;
            err   <= 1'b0;
            s     <= 1'b0;
            r     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            exp_q <= exp_nxt;
            err   <= err_nxt;
            s     <= s_nxt;
            r     <= r_nxt;
        end
    end

    assign cmd_ready = (state == IDLE)  && !rst;
    assign done      = (state == CHECK) && !rst;

endmodule
